// File: rtl/ksa_shuffle.sv
// RC4 key-scheduling swap phase: walks i over 0..255, accumulates j and swaps s[i]/s[j]
// in a shared 256x8 synchronous RAM with 1-cycle read latency.
module ksa_shuffle #(
  parameter int KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [KEY_BYTES*8-1:0] secret_key,
  input  logic [7:0]             s_q,
  output logic [7:0]             s_address,
  output logic [7:0]             s_data,
  output logic                   s_wren,
  output logic                   SHUFFLE_FINISHED
);

  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(KEY_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ_SI,
    S_WAIT_SI,
    S_READ_SJ,
    S_WAIT_SJ,
    S_WRITE_SI,
    S_WRITE_SJ,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [7:0]    r_i;
  logic [7:0]    r_j;
  logic [KW-1:0] r_k;
  logic [7:0]    r_s_i;
  logic [7:0]    r_s_j;

  logic [7:0]    w_key [KEY_BYTES];
  logic [7:0]    w_key_byte;

  // key[0] is the most significant byte of secret_key
  for (genvar g = 0; g < KEY_BYTES; g++) begin : g_key
    assign w_key[g] = secret_key[(KEY_BYTES-g)*8-1 -: 8];
  end
  assign w_key_byte = w_key[r_k];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_i     <= 8'd0;
      r_j     <= 8'd0;
      r_k     <= '0;
      r_s_i   <= 8'd0;
      r_s_j   <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE:    if (start) r_state <= S_READ_SI;
        S_READ_SI: r_state <= S_WAIT_SI;
        S_WAIT_SI: begin
          r_s_i   <= s_q;
          r_j     <= r_j + s_q + w_key_byte;
          r_state <= S_READ_SJ;
        end
        S_READ_SJ: r_state <= S_WAIT_SJ;
        S_WAIT_SJ: begin
          r_s_j   <= s_q;
          r_state <= S_WRITE_SI;
        end
        S_WRITE_SI: r_state <= S_WRITE_SJ;
        S_WRITE_SJ: begin
          if (r_i == 8'hFF) begin
            r_state <= S_DONE;
          end else begin
            r_i     <= r_i + 8'd1;
            r_k     <= (r_k == K_LAST) ? '0 : r_k + 1'b1;
            r_state <= S_READ_SI;
          end
        end
        S_DONE:    r_state <= S_DONE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  // The second write of an i==j swap carries the captured s[i], so s[i] is left unchanged.
  always_comb begin
    s_address        = r_i;
    s_data           = 8'd0;
    s_wren           = 1'b0;
    SHUFFLE_FINISHED = 1'b0;
    case (r_state)
      S_READ_SJ, S_WAIT_SJ: s_address = r_j;
      S_WRITE_SI: begin
        s_data = r_s_j;
        s_wren = 1'b1;
      end
      S_WRITE_SJ: begin
        s_address = r_j;
        s_data    = r_s_i;
        s_wren    = 1'b1;
      end
      S_DONE:  SHUFFLE_FINISHED = 1'b1;
      default: ;
    endcase
  end

endmodule
